// File: rtl/fp_add_sequencer.sv
// -----------------------------------------------------------------------------
// fp_add_sequencer
//
// Multi-cycle single-precision floating-point adder. Operands are unpacked and
// ordered by magnitude, the smaller significand is aligned one bit per cycle,
// the significands are added or subtracted, and the result is normalised one
// bit per cycle before being packed. Latency is traded for area: no barrel
// shifters, no leading-zero counter.
//
// Rounding is truncation (round toward zero). Denormal inputs are flushed to
// zero. An exponent overflow saturates to infinity and raises overflow.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands a/b present
//   in_ready   sequencer can accept operands (high only in idle)
//   a, b       packed operands {sign, exponent, fraction}
//   out_valid  sum/overflow valid, held until out_ready
//   out_ready  consumer accepts result
//   sum        packed result
//   overflow   result saturated to infinity (meaningful while out_valid=1)
//   busy       an operation is in flight
// -----------------------------------------------------------------------------
module fp_add_sequencer #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W  = MAN_W + 1;  // hidden bit + fraction
    localparam int unsigned ACC_W  = MAN_W + 2;  // carry + hidden bit + fraction

    localparam logic [EXP_W-1:0] EXP_ONES    = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE     = EXP_W'(1);
    // Beyond this distance every bit of the smaller significand is shifted out.
    localparam logic [EXP_W-1:0] SHAMT_LIMIT = EXP_W'(MAN_W + 1);

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

    state_e             state_q;
    logic               sign_q;      // result sign, taken from the larger operand
    logic               sub_q;       // operand signs differ
    logic [EXP_W-1:0]   exp_q;       // working exponent
    logic [EXP_W-1:0]   shamt_q;     // remaining alignment steps
    logic [SIG_W-1:0]   x_sig_q;     // larger-magnitude significand
    logic [SIG_W-1:0]   y_sig_q;     // smaller-magnitude significand, being aligned
    logic [ACC_W-1:0]   r_q;         // add/sub result, being normalised

    // -------------------------------------------------------------------------
    // Operand unpack and magnitude ordering (used only on acceptance)
    // -------------------------------------------------------------------------
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp,  b_exp;
    logic [SIG_W-1:0]   a_sig,  b_sig;
    logic               a_is_x;
    logic               x_sign, y_sign;
    logic [EXP_W-1:0]   x_exp,  y_exp;
    logic [SIG_W-1:0]   x_sig,  y_sig;
    logic [EXP_W-1:0]   shamt_in;

    always_comb begin
        a_sign = a[WORD_W-1];
        a_exp  = a[MAN_W +: EXP_W];
        // A zero exponent field means zero; any fraction bits are flushed.
        a_sig  = (a_exp == '0) ? '0 : {1'b1, a[MAN_W-1:0]};

        b_sign = b[WORD_W-1];
        b_exp  = b[MAN_W +: EXP_W];
        b_sig  = (b_exp == '0) ? '0 : {1'b1, b[MAN_W-1:0]};

        // Ties keep a as X, so the subtraction below never goes negative.
        a_is_x = (a_exp > b_exp) || ((a_exp == b_exp) && (a_sig >= b_sig));

        if (a_is_x) begin
            x_sign = a_sign;
            x_exp  = a_exp;
            x_sig  = a_sig;
            y_sign = b_sign;
            y_exp  = b_exp;
            y_sig  = b_sig;
        end else begin
            x_sign = b_sign;
            x_exp  = b_exp;
            x_sig  = b_sig;
            y_sign = a_sign;
            y_exp  = a_exp;
            y_sig  = a_sig;
        end

        shamt_in = x_exp - y_exp;
    end

    // -------------------------------------------------------------------------
    // Normalisation helpers
    // -------------------------------------------------------------------------
    logic [EXP_W-1:0] exp_inc;
    logic             r_carry;
    logic             r_hidden;
    logic             r_zero;

    always_comb begin
        exp_inc  = exp_q + EXP_ONE;
        r_carry  = r_q[ACC_W-1];
        r_hidden = r_q[MAN_W];
        r_zero   = (r_q == '0);
    end

    // -------------------------------------------------------------------------
    // Sequencer: state, datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            exp_q     <= '0;
            shamt_q   <= '0;
            x_sig_q   <= '0;
            y_sig_q   <= '0;
            r_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q   <= x_sign;
                        sub_q    <= x_sign ^ y_sign;
                        exp_q    <= x_exp;
                        x_sig_q  <= x_sig;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (shamt_in == '0) begin
                            y_sig_q <= y_sig;
                            shamt_q <= '0;
                            state_q <= StAdd;
                        end else if (shamt_in > SHAMT_LIMIT) begin
                            // Y cannot touch the result; skip alignment entirely.
                            y_sig_q <= '0;
                            shamt_q <= '0;
                            state_q <= StAdd;
                        end else begin
                            y_sig_q <= y_sig;
                            shamt_q <= shamt_in;
                            state_q <= StAlign;
                        end
                    end
                end

                StAlign: begin
                    // Shifted-out bits are dropped: truncating alignment.
                    y_sig_q <= y_sig_q >> 1;
                    shamt_q <= shamt_q - EXP_ONE;
                    if (shamt_q == EXP_ONE) begin
                        state_q <= StAdd;
                    end
                end

                StAdd: begin
                    if (sub_q) begin
                        r_q <= {1'b0, x_sig_q} - {1'b0, y_sig_q};
                    end else begin
                        r_q <= {1'b0, x_sig_q} + {1'b0, y_sig_q};
                    end
                    state_q <= StNorm;
                end

                StNorm: begin
                    if (r_carry) begin
                        // Carry out: one right shift always restores the hidden bit.
                        if (exp_inc == EXP_ONES) begin
                            sum      <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                            overflow <= 1'b1;
                        end else begin
                            sum      <= {sign_q, exp_inc, r_q[MAN_W:1]};
                            overflow <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else if (r_zero) begin
                        // Exact cancellation gives +0 regardless of operand signs.
                        sum       <= '0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else if (r_hidden) begin
                        sum       <= {sign_q, exp_q, r_q[MAN_W-1:0]};
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else if (exp_q <= EXP_ONE) begin
                        // Would underflow into the denormal range: flush to +0.
                        sum       <= '0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        r_q   <= r_q << 1;
                        exp_q <= exp_q - EXP_ONE;
                    end
                end

                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Multi-cycle controller that sequences a single-precision floating-point addition through unpack/compare, exponent-difference alignment, mantissa add/subtract, and normalization.
- Operands arrive on a valid/ready input handshake; the packed result leaves on a valid/ready output handshake.
- Sits between operand producers and any consumer needing an FP sum.
- Trades latency for area: shifts one bit per cycle instead of using barrel shifters.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width; word width is 1+EXP_W+MAN_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b present
- in_ready  output  1  sequencer can accept operands
- a  input  32  operand A, IEEE-754 packed {sign, exponent, fraction}
- b  input  32  operand B, same format
- out_valid  output  1  sum/overflow valid
- out_ready  input  1  consumer accepts result
- sum  output  32  packed result
- overflow  output  1  result saturated to infinity; meaningful only while out_valid=1
- busy  output  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, overflow=0, busy=0.
- Reset at any point discards the operation in flight; no partial output is produced.
- States: IDLE, ALIGN, ADD, NORM, DONE.

IDLE:
- in_ready=1.
- Accept on in_valid=1 at a clock edge (the acceptance edge, cycle 0).
- Unpack each operand: mantissa = {hidden, frac}, MAN_W+1 bits.
- Exponent field 0 means the operand is zero (fraction ignored; denormals are flushed).
- Swap so X has the larger magnitude (compare exponent, then mantissa); Y is the smaller.
- shamt = expX - expY.
- If shamt = 0, next state is ADD.
- If shamt > MAN_W+1, Y mantissa is forced to 0 and next state is ADD.
- Otherwise, next state is ALIGN.

ALIGN:
- Each cycle: Y mantissa shifts right 1 and shamt decrements by 1.
- Shifted-out bits are discarded (truncation, round toward zero).
- Leave for ADD when shamt reaches 0, so the state occupies exactly shamt cycles.

ADD (1 cycle):
- Signs equal: R = X + Y.
- Signs differ: R = X - Y.
- R is MAN_W+2 bits wide; R is never negative.
- Result sign = sign of X; result exponent = expX.

NORM (one step per cycle):
- Carry bit set: shift R right 1 and increment the exponent. If the new exponent equals all ones, result = {sign, all-ones, 0} and overflow=1. Go to DONE.
- R = 0: result = +0 (sign forced to 0). Go to DONE.
- Hidden bit = 1: pack the result. Go to DONE.
- Otherwise: shift R left 1, decrement the exponent, and stay in NORM. If the exponent would go below 1, result = +0 and go to DONE.

DONE:
- out_valid=1; sum and overflow are held stable until out_ready=1 at a clock edge.
- On that handshake, clear out_valid and return to IDLE.
- in_ready=0 in every state except IDLE; in_valid outside IDLE is ignored.

Latency:
- The first cycle with out_valid=1 is cycle (1 + shamt_eff + 1 + norm_cycles).
- shamt_eff = 0 when shamt = 0 or shamt > MAN_W+1, else shamt.
- norm_cycles = 1 + number of left shifts.
- Throughput: one operation in flight; the earliest next acceptance is the cycle after the output handshake.

Test Plan:
- a=3F800000, b=3F800000 (1.0+1.0), out_ready=1 -> sum=40000000, overflow=0, out_valid first high in cycle 3 after acceptance, single cycle.
- a=3F800000, b=3F000000 (1.0+0.5) -> sum=3FC00000, one ALIGN cycle, out_valid in cycle 4; swapping a/b gives an identical result and latency.
- a=3FC00000, b=BF800000 (1.5-1.0) -> sum=3F000000 after one NORM left shift; a=3F800000, b=BF800000 -> sum=00000000, overflow=0.
- a=7F7FFFFF, b=7F7FFFFF -> sum=7F800000, overflow=1; a=3F800000, b=30800000 (shamt>24) -> sum=3F800000, no ALIGN cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum stable, in_ready=0, a new in_valid is ignored; raise out_ready -> in_ready=1 next cycle, then the next operation is accepted.
- Assert rst during ALIGN (a=3F800000, b=3E800000) -> outputs return to reset values immediately; after release a fresh 1.0+1.0 yields 40000000 with normal latency.
